// File: rtl/sm_dip_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm_dip_filter_pkg
// Brief    : Shared definitions for the DIP switch filter (FSM encoding,
//            default debounce length).
// Revision : 1.0 - initial release
// ============================================================================
package sm_dip_filter_pkg;

    typedef enum logic {
        DIP_STABLE   = 1'b0,
        DIP_COUNTING = 1'b1
    } dipState_t;

    localparam int c_DIP_DEBOUNCE_DEFAULT = 16;

endpackage : sm_dip_filter_pkg
`default_nettype wire

// File: rtl/sm_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : sm_debounce_bit
// Brief    : One DIP bit: 2-flop synchronizer, STABLE/COUNTING FSM and
//            saturating-free stability counter driving the filtered level.
// Revision : 1.0 - initial release
// ============================================================================
module sm_debounce_bit
    import sm_dip_filter_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = c_DIP_DEBOUNCE_DEFAULT,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rawBit,
    output logic value,
    output logic update
);

    localparam int                 c_CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(DEBOUNCE_CYCLES);

    logic               r_syncMeta;
    logic               r_syncSample;
    logic               r_value;
    dipState_t          r_state;
    logic [c_CNT_W-1:0] r_count;

    dipState_t          w_nextState;
    logic [c_CNT_W-1:0] w_nextCount;
    logic [c_CNT_W-1:0] w_stepCount;
    logic               w_update;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syncMeta   <= RESET_BIT;
            r_syncSample <= RESET_BIT;
        end else begin
            r_syncMeta   <= rawBit;
            r_syncSample <= r_syncMeta;
        end
    end

    // Entering COUNTING loads 1, so a limit of 1 accepts on the first differing sample.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_update    = 1'b0;
        w_stepCount = (r_state == DIP_STABLE) ? c_CNT_ONE : (r_count + c_CNT_ONE);
        case (r_state)
            DIP_STABLE: begin
                if (r_syncSample != r_value) begin
                    if (w_stepCount == c_CNT_LIMIT) begin
                        w_update = 1'b1;
                    end else begin
                        w_nextState = DIP_COUNTING;
                        w_nextCount = w_stepCount;
                    end
                end
            end
            DIP_COUNTING: begin
                if (r_syncSample == r_value) begin
                    w_nextState = DIP_STABLE;
                    w_nextCount = '0;
                end else if (w_stepCount == c_CNT_LIMIT) begin
                    w_update    = 1'b1;
                    w_nextState = DIP_STABLE;
                    w_nextCount = '0;
                end else begin
                    w_nextCount = w_stepCount;
                end
            end
            default: begin
                w_nextState = DIP_STABLE;
                w_nextCount = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIP_STABLE;
            r_count <= '0;
            r_value <= RESET_BIT;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_update) begin
                r_value <= r_syncSample;
            end
        end
    end

    assign value  = r_value;
    assign update = w_update;

endmodule : sm_debounce_bit
`default_nettype wire

// File: rtl/sm_dip_filter.sv
`default_nettype none
// ============================================================================
// Module   : sm_dip_filter
// Brief    : Debounced DIP switch bank with optional change strobe.
//            Strobe enabled by defining SM_DIP_CHANGE_STROBE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sm_dip_filter
    import sm_dip_filter_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = c_DIP_DEBOUNCE_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dipRaw,
    output logic [WIDTH-1:0] dipValue,
    output logic             dipChanged
);

    logic [WIDTH-1:0] w_update;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sm_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[gi])
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .rawBit (dipRaw[gi]),
            .value  (dipValue[gi]),
            .update (w_update[gi])
        );
    end

`ifdef SM_DIP_CHANGE_STROBE_EN
    logic r_changed;

    // Registered on the same edge that loads dipValue, so the pulse lines up with the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_update;
        end
    end

    assign dipChanged = r_changed;
`else
    logic w_unusedUpdate;

    assign w_unusedUpdate = |w_update;
    assign dipChanged     = 1'b0;
`endif

endmodule : sm_dip_filter
`default_nettype wire

// File: tb/tb_sm_dip_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_dip_filter
// Brief    : Scoreboard bench for sm_dip_filter (WIDTH=8, DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_dip_filter;

    localparam int c_LATENCY = 6;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dipRaw = 8'h00;
    logic [7:0] dipValue;
    logic       dipChanged;

    typedef struct {
        logic [7:0] val;
        int         at;
    } exp_t;

    exp_t       expQ[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] prevValue = 8'h00;

    sm_dip_filter #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dipRaw     (dipRaw),
        .dipValue   (dipValue),
        .dipChanged (dipChanged)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Called at a negedge: the next posedge samples the new level.
    task automatic expectUpdate(input logic [7:0] v);
        exp_t e;
        e.val = v;
        e.at  = cyc + c_LATENCY;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        check("reset_dipValue", 32'(dipValue), 32'h00);
        check("reset_dipChanged", 32'(dipChanged), 32'h0);
        idle(2);
        rst_n = 1'b1;
    endtask

    // Monitor: every dipValue change must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValue = dipValue;
        end else begin
`ifdef SM_DIP_CHANGE_STROBE_EN
            check("dipChanged_pulse", 32'(dipChanged), 32'(dipValue != prevValue));
`else
            check("dipChanged_tied", 32'(dipChanged), 32'h0);
`endif
            if (dipValue != prevValue) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_update: got %0h at edge %0d, required no change",
                             dipValue, cyc);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("update_value", 32'(dipValue), 32'(e.val));
                    check("update_edge", 32'(cyc), 32'(e.at));
                end
            end
            prevValue = dipValue;
        end
    end

    initial begin
        #1;
        check("por_dipValue", 32'(dipValue), 32'h00);
        check("por_dipChanged", 32'(dipChanged), 32'h0);
        idle(3);
        rst_n = 1'b1;

        // Clean step 00 -> AA
        idle(1);
        dipRaw = 8'hAA;
        expectUpdate(8'hAA);
        idle(12);
        check("step_hold", 32'(dipValue), 32'hAA);

        // Glitch: bit0 high for 3 cycles
        doReset();
        dipRaw = 8'h00;
        idle(2);
        dipRaw = 8'h01;
        idle(3);
        dipRaw = 8'h00;
        idle(12);
        check("glitch_hold", 32'(dipValue), 32'h00);

        // Bounce on bit7, then held high
        dipRaw = 8'h80;
        idle(2);
        dipRaw = 8'h00;
        idle(2);
        dipRaw = 8'h80;
        expectUpdate(8'h80);
        idle(12);
        check("bounce_hold", 32'(dipValue), 32'h80);

        // Reset in the middle of a count
        dipRaw = 8'hFF;
        idle(3);
        rst_n = 1'b0;
        #1;
        check("midcount_reset_value", 32'(dipValue), 32'h00);
        idle(2);
        rst_n = 1'b1;
        expectUpdate(8'hFF);
        idle(12);
        check("midcount_recover", 32'(dipValue), 32'hFF);

        // Staggered bit1 / bit2 rises
        doReset();
        dipRaw = 8'h00;
        idle(2);
        dipRaw = 8'h02;
        expectUpdate(8'h02);
        idle(1);
        dipRaw = 8'h06;
        expectUpdate(8'h06);
        idle(12);

        // Clean fall back to 00
        dipRaw = 8'h00;
        expectUpdate(8'h00);
        idle(12);

        // Multi-bit glitch just below the limit
        dipRaw = 8'h55;
        idle(3);
        dipRaw = 8'h00;
        idle(12);
        check("multi_glitch_hold", 32'(dipValue), 32'h00);

        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL missing_updates: got %0d outstanding, required 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sm_dip_filter
`default_nettype wire

// File: doc/sm_dip_filter.md
SM_DIP_FILTER -- requirements
Module: sm_dip_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of DIP switch bits.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a new level; legal range 1..65535.
REQ-003 The block SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}: dipValue after reset.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 dipRaw  input  WIDTH  raw, asynchronous, bouncing switch levels.
REQ-007 dipValue  output  WIDTH  filtered switch levels, registered, driving the CPU dipValue input.
REQ-008 dipChanged  output  1  single-cycle registered pulse marking a dipValue update.

Function
REQ-009 Each bit SHALL pass through a 2-flop synchronizer before any other logic; the second flop is the bit's sampled value s.
REQ-010 Each bit SHALL run an independent two-state FSM: STABLE (s equals the bit's dipValue, counter held at 0) and COUNTING.
REQ-011 In STABLE, s differing from dipValue SHALL cause a move to COUNTING with the counter loaded to 1.
REQ-012 In COUNTING, s equal to dipValue (bounce back) SHALL clear the counter and return to STABLE with no output change.
REQ-013 In COUNTING, s still differing SHALL increment the counter; when the counter reaches DEBOUNCE_CYCLES, that edge SHALL load dipValue[bit] with s, clear the counter and return to STABLE.
REQ-014 Latency: a clean dipRaw step held constant SHALL appear on dipValue exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-015 A pulse on dipRaw shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change dipValue.
REQ-016 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) and the counter SHALL never wrap; it is cleared before it can exceed DEBOUNCE_CYCLES.
REQ-017 dipChanged SHALL be high for exactly the one cycle after any edge on which at least one dipValue bit changed; several bits changing on the same edge SHALL produce one single-cycle pulse.
REQ-018 Bits changing on consecutive edges SHALL produce back-to-back pulses, with no merging and no loss.
REQ-019 With DEBOUNCE_CYCLES = 1, a bit SHALL update on the edge after the first differing sample; STABLE/COUNTING semantics are unchanged.

Reset
REQ-020 Asserting rst_n low SHALL immediately force dipValue = RESET_VALUE, dipChanged = 0, all synchronizer flops = RESET_VALUE, all counters = 0 and all FSMs = STABLE, including in the middle of a count.
REQ-021 After reset release, a dipRaw differing from RESET_VALUE SHALL be accepted through the normal path, with the REQ-014 latency counted from the first post-reset edge.

Configuration
REQ-022 Macro SM_DIP_CHANGE_STROBE_EN SHALL control the change strobe: when defined, dipChanged behaves per REQ-017/018.
REQ-023 When SM_DIP_CHANGE_STROBE_EN is not defined, the dipChanged port SHALL still exist, be tied to constant 0, and no strobe register SHALL be synthesized; dipValue behaviour is unchanged.

Structure
REQ-024 FSM state encodings (STABLE=1'b0, COUNTING=1'b1) and the default DEBOUNCE_CYCLES value SHALL live in the shared CPU header/package alongside the existing sm_cpu definitions.
REQ-025 The per-bit synchronizer, FSM and counter SHALL be one sub-module, sm_debounce_bit, instantiated WIDTH times by a generate loop.
REQ-026 The top level SHALL contain only the generate loop, the OR-reduction of per-bit update flags and the dipChanged register.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, RESET_VALUE=8'h00)
REQ-027 Clean step: dipRaw 8'h00 -> 8'hAA, then held -> dipValue = 8'hAA on the 6th edge, dipChanged high for one cycle only.
REQ-028 Glitch: dipRaw bit0 high for 3 cycles, then low -> dipValue stays 8'h00 and dipChanged stays 0 throughout.
REQ-029 Bounce: bit7 goes high, returns low after 2 synchronized cycles, then goes high again and is held -> dipValue = 8'h80 exactly 6 edges after the final rise, with one pulse.
REQ-030 Reset mid-count: dipRaw = 8'hFF, rst_n pulsed low 3 edges later -> dipValue = 8'h00 immediately; 8'hFF appears 6 edges after release.
REQ-031 Staggered bits: bit1 rises, bit2 rises 1 cycle later -> dipValue goes 8'h02 then 8'h06 on consecutive edges, with two back-to-back dipChanged pulses.
REQ-032 Build without SM_DIP_CHANGE_STROBE_EN and rerun REQ-027 -> dipValue = 8'hAA on the 6th edge and dipChanged = 0 at all times.
